// File: rtl/mole_spawn_ctrl.sv
// Whack-a-target round controller: spawns targets into 4 slots on a fixed cadence,
// times each lit target, scores button hits and ends the round after MAX_MISS misses.
module mole_spawn_ctrl #(
  parameter int SPAWN_INTERVAL = 4,
  parameter int LIFETIME       = 8,
  parameter int MAX_MISS       = 3
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] rnd,
  input  logic [3:0] hit,
  output logic [3:0] active,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  localparam int SW = (SPAWN_INTERVAL > 2) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam int LW = (LIFETIME > 2) ? $clog2(LIFETIME) : 1;
  localparam logic [SW-1:0] SPAWN_RELOAD = SW'(SPAWN_INTERVAL - 1);
  localparam logic [LW-1:0] LIFE_RELOAD  = LW'(LIFETIME - 1);
  localparam logic [4:0]    MISS_LIMIT   = 5'(MAX_MISS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  logic [1:0]    r_state;
  logic [SW-1:0] r_spawn_cnt;
  logic [LW-1:0] r_life [4];
  logic [3:0]    r_active;
  logic [7:0]    r_score;
  logic [3:0]    r_misses;

  logic [3:0]        w_life_zero;
  logic [3:0]        w_good;
  logic [3:0]        w_wrong;
  logic [3:0]        w_expire;
  logic [3:0]        w_keep;
  logic              w_spawn_due;
  logic [3:0]        w_spawn;
  logic signed [9:0] w_score_sum;
  logic [7:0]        w_score_next;
  logic [4:0]        w_miss_sum;
  logic              w_round_end;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // First free slot walking upward from base, wrapping mod 4; zero if none free.
  function automatic logic [3:0] probe_pick(input logic [3:0] free, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    probe_pick = 4'b0000;
    found      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && free[idx]) begin
        probe_pick[idx] = 1'b1;
        found           = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_life_zero = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_life_zero[i] = (r_life[i] == '0);
    end
  end

  // A hit on the expiry edge wins over the miss.
  assign w_good      = r_active & hit;
  assign w_wrong     = ~r_active & hit;
  assign w_expire    = r_active & ~hit & w_life_zero;
  assign w_keep      = r_active & ~(w_good | w_expire);
  assign w_spawn_due = (r_spawn_cnt == '0);
  assign w_spawn     = w_spawn_due ? probe_pick(~r_active, rnd) : 4'b0000;

  assign w_score_sum = $signed({2'b00, r_score})
                     + $signed({7'b0000000, popcount4(w_good)})
                     - $signed({7'b0000000, popcount4(w_wrong)});

  always_comb begin
    w_score_next = w_score_sum[7:0];
    if (w_score_sum < 10'sd0) begin
      w_score_next = 8'd0;
    end else if (w_score_sum > 10'sd255) begin
      w_score_next = 8'd255;
    end
  end

  assign w_miss_sum  = {1'b0, r_misses} + {2'b00, popcount4(w_expire)};
  assign w_round_end = (w_miss_sum >= MISS_LIMIT);

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_spawn_cnt <= '0;
      r_active    <= 4'b0000;
      r_score     <= 8'd0;
      r_misses    <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_life[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            r_state     <= ST_PLAY;
            r_spawn_cnt <= SPAWN_RELOAD;
            r_active    <= 4'b0000;
            r_score     <= 8'd0;
            r_misses    <= 4'd0;
          end
        end
        ST_PLAY: begin
          r_spawn_cnt <= w_spawn_due ? SPAWN_RELOAD : r_spawn_cnt - SW'(1);
          r_score     <= w_score_next;
          for (int i = 0; i < 4; i++) begin
            if (w_spawn[i]) begin
              r_life[i] <= LIFE_RELOAD;
            end else if (r_active[i] && !w_life_zero[i]) begin
              r_life[i] <= r_life[i] - LW'(1);
            end
          end
          // The final miss discards this cycle's spawn and darkens the board.
          if (w_round_end) begin
            r_state  <= ST_OVER;
            r_active <= 4'b0000;
            r_misses <= MISS_LIMIT[3:0];
          end else begin
            r_active <= w_keep | w_spawn;
            r_misses <= w_miss_sum[3:0];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign active    = r_active;
  assign score     = r_score;
  assign misses    = r_misses;
  assign playing   = (r_state == ST_PLAY);
  assign game_over = (r_state == ST_OVER);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mole_spawn_ctrl.sv
// Bench for mole_spawn_ctrl: an edge-timestamp game model checked every cycle,
// plus directed rounds with hand-computed expectations.
module tb_mole_spawn_ctrl;

  localparam int SI = 4;
  localparam int LT = 8;
  localparam int MM = 3;

  logic       dclk;
  logic       rst;
  logic       start;
  logic [1:0] rnd;
  logic [3:0] hit;

  logic [3:0] active;
  logic [7:0] score;
  logic [3:0] misses;
  logic       playing;
  logic       game_over;
  logic [1:0] dbg_state;

  logic [3:0] b_active;
  logic [7:0] b_score;
  logic [3:0] b_misses;
  logic       b_playing;
  logic       b_game_over;
  logic [1:0] b_dbg_state;

  int tests;
  int fails;
  bit cmp_en;

  mole_spawn_ctrl #(.SPAWN_INTERVAL(SI), .LIFETIME(LT), .MAX_MISS(MM)) u_dut (
    .dclk(dclk), .rst(rst), .start(start), .rnd(rnd), .hit(hit),
    .active(active), .score(score), .misses(misses),
    .playing(playing), .game_over(game_over), .dbg_state(dbg_state)
  );

  // Fast-spawn, long-life instance that can fill the whole board.
  mole_spawn_ctrl #(.SPAWN_INTERVAL(2), .LIFETIME(16), .MAX_MISS(3)) u_dut_full (
    .dclk(dclk), .rst(rst), .start(start), .rnd(rnd), .hit(hit),
    .active(b_active), .score(b_score), .misses(b_misses),
    .playing(b_playing), .game_over(b_game_over), .dbg_state(b_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  // ---------------- model ----------------
  int         m_edge;
  int         m_state;        // 0 idle, 1 playing, 2 over
  int         m_start_edge;
  int         m_spawn_at [4];
  logic [3:0] m_lit;
  int         m_score;
  int         m_misses;

  task automatic model_step();
    logic [3:0] lit0;
    logic [3:0] keep;
    int good, wrong, expd, pick, idx;
    if (m_state != 1) begin
      if (start) begin
        m_state      = 1;
        m_start_edge = m_edge;
        m_score      = 0;
        m_misses     = 0;
        m_lit        = 4'b0000;
      end
    end else begin
      lit0  = m_lit;
      keep  = m_lit;
      good  = 0;
      wrong = 0;
      expd  = 0;
      pick  = -1;
      for (int i = 0; i < 4; i++) begin
        if (lit0[i]) begin
          if (hit[i]) begin
            good++;
            keep[i] = 1'b0;
          end else if (m_edge - m_spawn_at[i] >= LT) begin
            expd++;
            keep[i] = 1'b0;
          end
        end else if (hit[i]) begin
          wrong++;
        end
      end
      if (m_edge > m_start_edge && ((m_edge - m_start_edge) % SI) == 0) begin
        for (int k = 0; k < 4; k++) begin
          idx = (int'(rnd) + k) % 4;
          if (pick < 0 && !lit0[idx]) pick = idx;
        end
      end
      m_score = m_score + good - wrong;
      if (m_score < 0) m_score = 0;
      if (m_score > 255) m_score = 255;
      m_misses = m_misses + expd;
      if (m_misses >= MM) begin
        m_misses = MM;
        m_state  = 2;
        m_lit    = 4'b0000;
      end else begin
        m_lit = keep;
        if (pick >= 0) begin
          m_lit[pick]      = 1'b1;
          m_spawn_at[pick] = m_edge;
        end
      end
    end
  endtask

  always @(posedge dclk or posedge rst) begin
    if (rst) begin
      m_state  = 0;
      m_lit    = 4'b0000;
      m_score  = 0;
      m_misses = 0;
      m_edge   = 0;
      for (int i = 0; i < 4; i++) m_spawn_at[i] = 0;
    end else begin
      model_step();
      m_edge++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input int dut_v, input int mdl_v, input int want);
    chk({name, "_dut"}, dut_v, want);
    chk({name, "_model"}, mdl_v, want);
  endtask

  always @(negedge dclk) begin
    if (!rst && cmp_en) begin
      chk("active", int'(active), int'(m_lit));
      chk("score", int'(score), m_score);
      chk("misses", int'(misses), m_misses);
      chk("playing", int'(playing), int'(m_state == 1));
      chk("game_over", int'(game_over), int'(m_state == 2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic s, input logic [1:0] r, input logic [3:0] h);
    start = s;
    rnd   = r;
    hit   = h;
    @(negedge dclk);
    start = 1'b0;
    hit   = 4'b0000;
  endtask

  task automatic idle(input int n, input logic [1:0] r);
    for (int i = 0; i < n; i++) cyc(1'b0, r, 4'b0000);
  endtask

  task automatic do_reset();
    @(negedge dclk);
    rst = 1'b1;
    @(negedge dclk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed rounds ----------------
  initial begin
    tests  = 0;
    fails  = 0;
    cmp_en = 1'b0;
    rst    = 1'b1;
    start  = 1'b0;
    rnd    = 2'd0;
    hit    = 4'b0000;
    repeat (2) @(negedge dclk);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Reset values, start latency, first spawn, expiry
    pin("rst_active", int'(active), int'(m_lit), 0);
    pin("rst_score", int'(score), m_score, 0);
    pin("rst_misses", int'(misses), m_misses, 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_game_over", int'(game_over), 0);
    cyc(1'b1, 2'd2, 4'b0000);                              // edge 0
    pin("start_playing", int'(playing), int'(m_state == 1), 1);
    idle(3, 2'd2);                                         // edges 1..3
    pin("no_spawn_before_4", int'(active), int'(m_lit), 0);
    cyc(1'b0, 2'd2, 4'b0000);                              // edge 4
    pin("first_spawn", int'(active), int'(m_lit), 4'b0100);
    idle(7, 2'd2);                                         // edges 5..11
    pin("lit_through_11", int'(active), int'(m_lit), 4'b1100);
    cyc(1'b0, 2'd2, 4'b0000);                              // edge 12
    pin("expire_12", int'(active), int'(m_lit), 4'b1001);
    pin("miss_1", int'(misses), m_misses, 1);
    pin("score_0", int'(score), m_score, 0);

    // Good hit, wrong hits clamping at 0, saturation at 255
    do_reset();
    cyc(1'b1, 2'd2, 4'b0000);
    idle(3, 2'd2);
    cyc(1'b0, 2'd2, 4'b0000);                              // edge 4: slot 2 lit
    cyc(1'b0, 2'd2, 4'b0000);
    cyc(1'b0, 2'd2, 4'b0100);                              // edge 6: good hit
    pin("good_hit_active", int'(active), int'(m_lit), 0);
    pin("good_hit_score", int'(score), m_score, 1);
    cyc(1'b0, 2'd2, 4'b0011);                              // edge 7: two wrong hits
    pin("wrong_clamp", int'(score), m_score, 0);
    for (int i = 0; i < 1040; i++) cyc(1'b0, 2'd2, m_lit);
    pin("score_sat", int'(score), m_score, 255);
    pin("sat_misses", int'(misses), m_misses, 0);

    // Collision probe, hit on expiry edge, hit on spawning slot
    do_reset();
    cyc(1'b1, 2'd1, 4'b0000);
    idle(3, 2'd1);
    cyc(1'b0, 2'd1, 4'b0000);                              // edge 4: slot 1
    pin("spawn_s1", int'(active), int'(m_lit), 4'b0010);
    idle(3, 2'd1);
    cyc(1'b0, 2'd2, 4'b0000);                              // edge 8: slot 2
    pin("spawn_s2", int'(active), int'(m_lit), 4'b0110);
    idle(3, 2'd1);
    cyc(1'b0, 2'd1, 4'b0000);                              // edge 12: probe skips 1,2
    pin("collision", int'(active), int'(m_lit), 4'b1100);
    pin("collision_miss", int'(misses), m_misses, 1);
    idle(3, 2'd1);
    cyc(1'b0, 2'd1, 4'b0100);                              // edge 16: hit on expiry
    pin("expiry_hit_score", int'(score), m_score, 1);
    pin("expiry_hit_miss", int'(misses), m_misses, 1);
    pin("expiry_hit_active", int'(active), int'(m_lit), 4'b1010);
    cyc(1'b0, 2'd1, 4'b1000);                              // edge 17
    idle(2, 2'd1);
    cyc(1'b0, 2'd1, 4'b0100);                              // edge 20: hit spawning slot
    pin("spawn_hit_score", int'(score), m_score, 1);
    pin("spawn_hit_active", int'(active), int'(m_lit), 4'b0110);

    // Full board on the fast instance: no spawn, no penalty
    do_reset();
    cyc(1'b1, 2'd1, 4'b0000);
    idle(10, 2'd1);                                        // edges 1..10
    chk("full_active_10", int'(b_active), 4'b1111);
    chk("full_misses_10", int'(b_misses), 0);
    idle(2, 2'd1);                                         // edges 11..12
    chk("full_active_12", int'(b_active), 4'b1111);
    chk("full_misses_12", int'(b_misses), 0);

    // Game over, frozen score, restart, async reset
    do_reset();
    cyc(1'b1, 2'd0, 4'b0000);
    idle(3, 2'd0);
    cyc(1'b0, 2'd0, 4'b0000);                              // edge 4: slot 0
    cyc(1'b0, 2'd0, 4'b0001);                              // edge 5: good hit
    idle(18, 2'd0);                                        // edges 6..23
    pin("pre_over_misses", int'(misses), m_misses, 2);
    cyc(1'b0, 2'd0, 4'b0000);                              // edge 24: third miss
    pin("over_flag", int'(game_over), int'(m_state == 2), 1);
    pin("over_active", int'(active), int'(m_lit), 0);
    pin("over_score", int'(score), m_score, 1);
    pin("over_misses", int'(misses), m_misses, 3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'(i), 4'b1111);
    pin("over_hits_ignored", int'(score), m_score, 1);
    cyc(1'b1, 2'd0, 4'b0000);                              // restart
    pin("restart_playing", int'(playing), int'(m_state == 1), 1);
    pin("restart_score", int'(score), m_score, 0);
    pin("restart_misses", int'(misses), m_misses, 0);
    idle(3, 2'd0);
    cyc(1'b0, 2'd0, 4'b0000);
    cyc(1'b0, 2'd0, 4'b0001);
    idle(2, 2'd0);
    cyc(1'b0, 2'd0, 4'b0000);
    pin("pre_rst_score", int'(score), m_score, 1);
    pin("pre_rst_active", int'(active), int'(m_lit), 4'b0001);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_active", int'(active), 0);
    chk("async_rst_score", int'(score), 0);
    chk("async_rst_misses", int'(misses), 0);
    chk("async_rst_playing", int'(playing), 0);
    chk("async_rst_game_over", int'(game_over), 0);
    @(negedge dclk);
    rst = 1'b0;
    idle(2, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mole_spawn_ctrl.md
Name: mole_spawn_ctrl

Overview:
Game-round controller for the whack-a-target game. It samples the free-running 2-bit random number from the random generator to light targets in 4 slots. It times each lit target, scores button hits and counts misses, and ends the round after MAX_MISS misses. It sits between the random generator, the debounced button pulses and the display/score logic, and is clocked by the game clock.

Parameters:
SPAWN_INTERVAL, 4, dclk cycles between spawn attempts (>=2)
LIFETIME, 8, dclk cycles a spawned target stays lit (>=2)
MAX_MISS, 3, misses that end the round (1..15)

Ports:
dclk  input  1  game clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a round from IDLE or OVER
rnd  input  2  random slot index from the random generator, sampled on spawn cycles only
hit  input  4  single-cycle button pulses, one per slot
active  output  4  lit-target mask, registered
score  output  8  round score, registered, unsigned
misses  output  4  miss count, registered
playing  output  1  high in PLAY
game_over  output  1  high in OVER

Behaviour:
- Reset (asynchronous, any time, including mid-round):
  - state=IDLE; active=0, score=0, misses=0, playing=0, game_over=0.
  - spawn counter=0; all four life counters=0.
- States:
  - IDLE: start -> PLAY. On that edge, load spawn counter with SPAWN_INTERVAL-1 and clear score, misses and active.
  - PLAY: spawn counter decrements each edge. On the edge where it is 0, perform a spawn and reload it with SPAWN_INTERVAL-1.
  - OVER: active=0 and score/misses are held. start -> PLAY, with the same loading and clearing as from IDLE.
  - start is ignored in PLAY.
- Spawn (in PLAY):
  - Candidate slots are those with active=0 at the start of the cycle.
  - Probe order: rnd, rnd+1, rnd+2, rnd+3, all mod 4. Pick the first candidate.
  - The chosen slot gets active=1 and its life counter loaded with LIFETIME-1, both visible after the spawn edge.
  - All 4 slots lit: no spawn and no penalty; the spawn counter still reloads.
- Life counters:
  - Each lit slot decrements every edge.
  - An edge where the life counter is 0 and there is no hit on that slot: clear the slot and count one miss.
  - A target is therefore lit for exactly LIFETIME cycles.
- Hits (in PLAY, evaluated against active at start of cycle):
  - Hit on a lit slot is a good hit: clear the slot.
  - Hit on an unlit slot is a wrong hit.
  - Hit on the expiry edge counts as a good hit, not a miss.
  - Hit on a slot spawning this same cycle is a wrong hit; the spawn still occurs.
  - Slots cleared this cycle by hit or expiry are not spawn candidates this cycle.
- Score:
  - new score = score + (good count) - (wrong count), computed in 10-bit signed arithmetic.
  - Saturate to 0..255.
  - Multiple simultaneous hits are all counted.
- Misses:
  - misses += (expiries this cycle), saturating at MAX_MISS.
  - When the updated value reaches MAX_MISS: go to OVER on the same edge and clear active.
  - Good/wrong hits and spawns in that final cycle still update score but spawns are discarded.
- Outside PLAY: hit and rnd are ignored; counters are frozen.

Test Plan:
- Reset/start latency: rst pulse, then start sampled at edge 0 with rnd=2 held -> playing=1 after edge 0; active=4'b0100 after edge 4 (SPAWN_INTERVAL=4), not before.
- Expiry and miss: no hits after the spawn at edge 4 -> active[2] high for edges 4..11, cleared at edge 12, misses=1, score=0.
- Good/wrong hits and saturation:
  - hit[2] at cycle 6 -> active[2]=0, score=1.
  - Then hit=4'b0011 on unlit slots -> score=0, not negative.
  - With score at 255, a good hit leaves score=255.
- Collision probe: rnd held at 1 with slots 1 and 2 lit -> spawn lights slot 3. With all 4 lit -> active unchanged, no miss.
- Simultaneous events:
  - Hit on a slot's expiry edge -> score+1, misses unchanged.
  - Hit on the slot being spawned -> score-1 (from >=1), slot lit next cycle.
- Game over and restart:
  - 3 expiries -> game_over=1, active=0, score held.
  - Further hits do not change score.
  - start -> PLAY with score=0, misses=0.
  - rst asserted mid-round -> all outputs 0 immediately, without waiting for a clock edge.
